// File: rtl/noc_packetizer_if.sv
// rtl/noc_packetizer_if.sv - request, payload and router-port handshake bundle for noc_packetizer
interface noc_packetizer_if #(
   parameter int WORD_WIDTH = 32,
   parameter int LEN_W      = 5
);
   logic                  req_valid;
   logic                  req_ready;
   logic [2:0]            req_dst_x;
   logic [2:0]            req_dst_y;
   logic [LEN_W-1:0]      req_len;
   logic                  pay_valid;
   logic                  pay_ready;
   logic [29:0]           pay_data;
   logic [WORD_WIDTH-1:0] data_out;
   logic                  data_void_out;
   logic                  stop_in;
   logic                  busy;

   // master: core plus router side of the block; slave: the packetizer itself
   modport master (
      output req_valid, req_dst_x, req_dst_y, req_len, pay_valid, pay_data, stop_in,
      input  req_ready, pay_ready, data_out, data_void_out, busy
   );

   modport slave (
      input  req_valid, req_dst_x, req_dst_y, req_len, pay_valid, pay_data, stop_in,
      output req_ready, pay_ready, data_out, data_void_out, busy
   );
endinterface

// File: rtl/noc_packetizer.sv
// rtl/noc_packetizer.sv - HEAD/BODY/TAIL flit packetizer with XY lookahead and void/stop flow control
// Optional feature macro: PKT_SEQ_EN (6-bit packet sequence number in TAIL bits [7:2]).
module noc_packetizer #(
   parameter int WORD_WIDTH = 32,
   parameter int X_POS      = 0,
   parameter int Y_POS      = 0,
   parameter int MAX_LEN    = 16,
   parameter int LEN_W      = 5
) (
   input logic             clk,
   input logic             rst,
   noc_packetizer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BODY, TAIL} state_t;

   localparam logic [2:0]       X3      = 3'(X_POS);
   localparam logic [2:0]       Y3      = 3'(Y_POS);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

   state_t                  state;
   logic [WORD_WIDTH-1:0]   out_q;
   logic                    out_v;
   logic [LEN_W-1:0]        cnt;
   logic                    slot_free;
   logic                    req_fire;
   logic                    pay_fire;
   logic                    tail_load;
   logic [LEN_W-1:0]        len_c;
   logic [5:0]              seq_bits;
   logic [WORD_WIDTH-1:0]   head_flit;
   logic [WORD_WIDTH-1:0]   body_flit;
   logic [WORD_WIDTH-1:0]   tail_flit;

   function automatic logic [4:0] lookahead(input logic [2:0] dx, input logic [2:0] dy);
      if (dx > X3)      return 5'b00010;
      else if (dx < X3) return 5'b00100;
      else if (dy > Y3) return 5'b01000;
      else if (dy < Y3) return 5'b10000;
      else              return 5'b00001;
   endfunction

   // The output slot can take a new flit if empty or if its flit leaves this edge
   assign slot_free = ~out_v | ~bus.stop_in;
   assign req_fire  = bus.req_valid & bus.req_ready;
   assign pay_fire  = bus.pay_valid & bus.pay_ready;
   assign tail_load = rst & (state == TAIL) & slot_free;
   assign len_c     = (bus.req_len > LEN_MAX) ? LEN_MAX : bus.req_len;

   assign head_flit = {2'b10, 6'd0, bus.req_dst_x, bus.req_dst_y, 13'd0,
                       lookahead(bus.req_dst_x, bus.req_dst_y)};
   assign body_flit = {2'b00, bus.pay_data};
   assign tail_flit = {2'b01, 16'd0, X3, Y3, seq_bits, 2'b00};

   // Handshakes and outputs are forced quiet while reset is held
   assign bus.req_ready     = rst & (state == IDLE) & slot_free;
   assign bus.pay_ready     = rst & (state == BODY) & slot_free;
   assign bus.data_out      = rst ? out_q : '0;
   assign bus.data_void_out = ~(rst & out_v);
   assign bus.busy          = rst & ((state != IDLE) | out_v);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         out_q <= '0;
         out_v <= 1'b0;
         cnt   <= '0;
      end else begin
         if (slot_free) out_v <= 1'b0;
         case (state)
            IDLE: begin
               if (req_fire) begin
                  out_q <= head_flit;
                  out_v <= 1'b1;
                  cnt   <= len_c;
                  state <= (len_c != '0) ? BODY : TAIL;
               end
            end
            BODY: begin
               if (pay_fire) begin
                  out_q <= body_flit;
                  out_v <= 1'b1;
                  cnt   <= cnt - 1'b1;
                  if (cnt == LEN_W'(1)) state <= TAIL;
               end
            end
            TAIL: begin
               if (slot_free) begin
                  out_q <= tail_flit;
                  out_v <= 1'b1;
                  cnt   <= '0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef PKT_SEQ_EN
   logic [5:0] seq;

   always_ff @(posedge clk) begin
      if (!rst)           seq <= 6'd0;
      else if (tail_load) seq <= seq + 6'd1;
   end

   assign seq_bits = seq;
`else
   assign seq_bits = 6'd0;
`endif
endmodule
